serial_word_comparator: RTL

//  Multi-cycle magnitude comparator for WIDTH-bit unsigned operands a and b.

---
 rtl/serial_word_comparator_pkg.sv | 35 +++
 rtl/cmp2_slice.sv | 29 ++
 rtl/serial_word_comparator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_word_comparator_pkg.sv
// ---------------------------------------------------------------------------
// serial_word_comparator_pkg
//   Shared encodings for the serial word comparator:
//     - FSM state codes (SWC_IDLE / SWC_RUN / SWC_DONE)
//     - running verdict codes (V_EQ / V_GT / V_LT)
//   It also provides the helper that folds one digit's result into the
//   running verdict.
// ---------------------------------------------------------------------------
package serial_word_comparator_pkg;

  localparam logic [1:0] SWC_IDLE = 2'd0;
  localparam logic [1:0] SWC_RUN  = 2'd1;
  localparam logic [1:0] SWC_DONE = 2'd2;

  localparam logic [1:0] V_EQ = 2'd0;
  localparam logic [1:0] V_GT = 2'd1;
  localparam logic [1:0] V_LT = 2'd2;

  // Once a digit has decided the order, later digits cannot change it.
  // dig is the slice output packed as {gt, eq, lt}, which is one-hot.
  function automatic logic [1:0] merge_verdict(input logic [1:0] cur,
                                               input logic [2:0] dig);
    logic [1:0] res;
    res = cur;
    if (cur == V_EQ) begin
      case (dig)
        3'b100:  res = V_GT;
        3'b001:  res = V_LT;
        default: res = V_EQ;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// ---------------------------------------------------------------------------
// cmp2_slice
//   Purely combinational magnitude compare of one 2-bit unsigned digit.
//   Ports:
//     a1, a0  in  digit of operand A (a1 = MSB)
//     b1, b0  in  digit of operand B (b1 = MSB)
//     gt      out {a1,a0} >  {b1,b0}
//     eq      out {a1,a0} == {b1,b0}
//     lt      out {a1,a0} <  {b1,b0}
//   Exactly one of gt/eq/lt is high.
// ---------------------------------------------------------------------------
module cmp2_slice (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic gt,
  output logic eq,
  output logic lt
);

  logic hi_eq;

  assign hi_eq = ~(a1 ^ b1);
  assign gt    = (a1 & ~b1) | (hi_eq & a0 & ~b0);
  assign eq    = hi_eq & ~(a0 ^ b0);
  assign lt    = ~gt & ~eq;

endmodule

// File: rtl/serial_word_comparator.sv
// ---------------------------------------------------------------------------
// serial_word_comparator
//   Multi-cycle unsigned magnitude comparator. The two operands are walked
//   MSB-first, one 2-bit digit per clock, through cmp2_slice. The first
//   non-equal digit fixes the verdict. Results are registered and held until
//   the next completion.
//
//   Parameters:
//     WIDTH  operand width (even, >= 2); N = WIDTH/2 digits
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only in IDLE
//     a, b   in   operands, captured on the accepted start edge
//     busy   out  high while comparing (RUN)
//     done   out  one-cycle completion pulse (DONE)
//     gt     out  a >  b, held until next completion
//     eq     out  a == b, held until next completion
//     lt     out  a <  b, held until next completion
//
//   Build option:
//     SWC_EARLY_EXIT_EN  when defined, RUN ends on the first non-equal digit
//                        instead of always consuming all N digits.
// ---------------------------------------------------------------------------
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic [1:0]       verdict;

  logic             dig_gt;
  logic             dig_eq;
  logic             dig_lt;
  logic [1:0]       nxt_verdict;
  logic             last_digit;

  // Only the current top digit of each shift register is ever examined.
  cmp2_slice u_slice (
    .a1 (sa[WIDTH-1]),
    .a0 (sa[WIDTH-2]),
    .b1 (sb[WIDTH-1]),
    .b0 (sb[WIDTH-2]),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  always_comb begin
    nxt_verdict = merge_verdict(verdict, {dig_gt, dig_eq, dig_lt});
`ifdef SWC_EARLY_EXIT_EN
    // The verdict is still EQ on entry to every RUN cycle. A non-EQ result
    // here therefore means this digit is the first mismatch.
    last_digit  = (cnt == CW'(1)) || (nxt_verdict != V_EQ);
`else
    last_digit  = (cnt == CW'(1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SWC_IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      verdict <= V_EQ;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        SWC_IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CW'(N);
            verdict <= V_EQ;
            state   <= SWC_RUN;
          end
        end
        SWC_RUN: begin
          sa      <= sa << 2;
          sb      <= sb << 2;
          cnt     <= cnt - CW'(1);
          verdict <= nxt_verdict;
          if (last_digit) begin
            state <= SWC_DONE;
            gt    <= (nxt_verdict == V_GT);
            eq    <= (nxt_verdict == V_EQ);
            lt    <= (nxt_verdict == V_LT);
          end
        end
        SWC_DONE: begin
          state <= SWC_IDLE;
        end
        default: begin
          state <= SWC_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SWC_RUN);
  assign done = (state == SWC_DONE);

endmodule
